// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: two-channel read-side scheduler for the sample FIFOs.
// Drains two channel FIFOs in bursts of up to BURST_LEN words into a single
// tagged output stream. Grant order is round-robin unless exactly one of two
// competing channels reports almost-full, which then wins. Read data arrives
// one cycle after the strobe and is parked in a 2-entry skid buffer that
// drives the output handshake.
//
// Ports:
//   clk_i                      single clock (FIFO read clock)
//   rst_i                      synchronous active-high reset
//   en_i[1:0]                  per-channel enable
//   clr_ovf_i                  clears the sticky overflow flags
//   chN_empty_i/a_full_i/full_i FIFO status flags of channel N
//   chN_rd_en_o                FIFO read strobe of channel N (combinational)
//   chN_data_i                 FIFO read data, valid the cycle after a strobe
//   out_valid_o/out_ready_i    output handshake
//   out_data_o/chan_o/last_o   output word, its source channel, end of burst
//   ovf_o[1:0]                 sticky per-channel overflow flags
//   busy_o                     high while a burst is being granted
module fifo_rd_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [1:0]            en_i,
   input  logic                  clr_ovf_i,
   input  logic                  ch0_empty_i,
   input  logic                  ch1_empty_i,
   input  logic                  ch0_a_full_i,
   input  logic                  ch1_a_full_i,
   input  logic                  ch0_full_i,
   input  logic                  ch1_full_i,
   output logic                  ch0_rd_en_o,
   output logic                  ch1_rd_en_o,
   input  logic [DATA_WIDTH-1:0] ch0_data_i,
   input  logic [DATA_WIDTH-1:0] ch1_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_chan_o,
   output logic                  out_last_o,
   output logic [1:0]            ovf_o,
   output logic                  busy_o
);

   typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

   localparam logic [CNT_WIDTH-1:0] BURST_MAX = CNT_WIDTH'(BURST_LEN);

   state_t                 state_r, state_nxt_s;
   logic                   grant_r, grant_nxt_s;
   logic                   last_grant_r, last_grant_nxt_s;
   logic [CNT_WIDTH-1:0]   count_r, count_nxt_s;
   logic                   infl_r, infl_chan_r, infl_last_r;

   logic [DATA_WIDTH-1:0]  buf_data_r [2];
   logic [1:0]             buf_chan_r, buf_last_r;
   logic                   wr_ptr_r, rd_ptr_r;
   logic [1:0]             occ_r;
   logic [1:0]             ovf_r;

   logic [1:0]             elig_s;
   logic                   sel_s, g_en_s, g_empty_s;
   logic                   pop_s, space_s, strobe_s, last_tag_s, late_mark_s, cnt_hit_s;
   logic [2:0]             fill_s;
   logic [DATA_WIDTH-1:0]  cap_data_s;

   // Shared status terms: eligibility, granted-channel flags, buffer space.
   always_comb begin
      elig_s     = en_i & ~{ch1_empty_i, ch0_empty_i};
      g_en_s     = grant_r ? en_i[1] : en_i[0];
      g_empty_s  = grant_r ? ch1_empty_i : ch0_empty_i;
      pop_s      = (occ_r != 2'd0) && out_ready_i;
      // Words already buffered plus the one in flight, less the one leaving now.
      fill_s     = {1'b0, occ_r} + {2'b00, infl_r} - {2'b00, pop_s};
      space_s    = (fill_s < 3'd2);
      cnt_hit_s  = ((count_r + CNT_WIDTH'(1)) == BURST_MAX);
      cap_data_s = infl_chan_r ? ch1_data_i : ch0_data_i;
   end

   // Grant selection, burst sequencing and read-strobe generation.
   always_comb begin
      state_nxt_s      = state_r;
      grant_nxt_s      = grant_r;
      last_grant_nxt_s = last_grant_r;
      count_nxt_s      = count_r;
      sel_s            = 1'b0;
      strobe_s         = 1'b0;
      last_tag_s       = 1'b0;
      late_mark_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (elig_s != 2'b00) begin
               if (elig_s == 2'b01) begin
                  sel_s = 1'b0;
               end else if (elig_s == 2'b10) begin
                  sel_s = 1'b1;
               end else if (ch0_a_full_i != ch1_a_full_i) begin
                  sel_s = ch1_a_full_i;
               end else begin
                  sel_s = ~last_grant_r;
               end
               state_nxt_s      = ST_BURST;
               grant_nxt_s      = sel_s;
               last_grant_nxt_s = sel_s;
               count_nxt_s      = '0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BURST: begin
            strobe_s = g_en_s && !g_empty_s && space_s && (count_r < BURST_MAX);
            if (strobe_s) begin
               count_nxt_s = count_r + CNT_WIDTH'(1);
               last_tag_s  = cnt_hit_s;
               state_nxt_s = cnt_hit_s ? ST_IDLE : ST_BURST;
            end else if (g_empty_s || !g_en_s || (count_r >= BURST_MAX)) begin
               // Early exit: the most recent word of this grant becomes the last.
               state_nxt_s = ST_IDLE;
               late_mark_s = (count_r != '0);
            end else begin
               state_nxt_s = ST_BURST;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      // No FIFO may be read while the arbiter is being reset.
      if (rst_i) begin
         strobe_s = 1'b0;
      end else begin
         strobe_s = strobe_s;
      end
   end

   // FSM state, grant history and in-flight read tracking.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= ST_IDLE;
         grant_r      <= 1'b0;
         last_grant_r <= 1'b1;
         count_r      <= '0;
         infl_r       <= 1'b0;
         infl_chan_r  <= 1'b0;
         infl_last_r  <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         grant_r      <= grant_nxt_s;
         last_grant_r <= last_grant_nxt_s;
         count_r      <= count_nxt_s;
         infl_r       <= strobe_s;
         infl_chan_r  <= grant_r;
         infl_last_r  <= last_tag_s;
      end
   end

   // Two-entry skid buffer: capture read data, pop on handshake, late last marking.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         buf_data_r[0] <= '0;
         buf_data_r[1] <= '0;
         buf_chan_r    <= 2'b00;
         buf_last_r    <= 2'b00;
         wr_ptr_r      <= 1'b0;
         rd_ptr_r      <= 1'b0;
         occ_r         <= 2'd0;
      end else begin
         if (infl_r) begin
            buf_data_r[wr_ptr_r] <= cap_data_s;
            buf_chan_r[wr_ptr_r] <= infl_chan_r;
            buf_last_r[wr_ptr_r] <= infl_last_r | late_mark_s;
            wr_ptr_r             <= ~wr_ptr_r;
         end else if (late_mark_s) begin
            // Only reachable after a space stall, so the tail is never the entry being popped.
            buf_last_r[~wr_ptr_r] <= 1'b1;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         occ_r <= occ_r + {1'b0, infl_r} - {1'b0, pop_s};
      end
   end

   // Sticky overflow flags; a set in the same cycle as a clear wins.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf_r <= 2'b00;
      end else begin
         ovf_r[0] <= ch0_full_i | (ovf_r[0] & ~clr_ovf_i);
         ovf_r[1] <= ch1_full_i | (ovf_r[1] & ~clr_ovf_i);
      end
   end

   assign ch0_rd_en_o = strobe_s && !grant_r;
   assign ch1_rd_en_o = strobe_s && grant_r;
   assign out_valid_o = (occ_r != 2'd0);
   assign out_data_o  = buf_data_r[rd_ptr_r];
   assign out_chan_o  = buf_chan_r[rd_ptr_r];
   assign out_last_o  = buf_last_r[rd_ptr_r];
   assign ovf_o       = ovf_r;
   assign busy_o      = (state_r == ST_BURST);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Testbench for fifo_rd_arbiter: grant table, directed multi-cycle sequences
// and randomized back-pressure runs compared with a transaction-level model.
module tb_fifo_rd_arbiter;
   localparam int DW = 32;
   localparam int BL = 4;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [1:0]    en_i;
   logic          clr_ovf_i;
   logic          ch0_empty_i, ch1_empty_i;
   logic          ch0_a_full_i, ch1_a_full_i;
   logic          ch0_full_i, ch1_full_i;
   logic          ch0_rd_en_o, ch1_rd_en_o;
   logic [DW-1:0] ch0_data_i, ch1_data_i;
   logic          out_valid_o, out_ready_i;
   logic [DW-1:0] out_data_o;
   logic          out_chan_o, out_last_o;
   logic [1:0]    ovf_o;
   logic          busy_o;

   always #5 clk = ~clk;

   fifo_rd_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(8)) dut (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clr_ovf_i(clr_ovf_i),
      .ch0_empty_i(ch0_empty_i), .ch1_empty_i(ch1_empty_i),
      .ch0_a_full_i(ch0_a_full_i), .ch1_a_full_i(ch1_a_full_i),
      .ch0_full_i(ch0_full_i), .ch1_full_i(ch1_full_i),
      .ch0_rd_en_o(ch0_rd_en_o), .ch1_rd_en_o(ch1_rd_en_o),
      .ch0_data_i(ch0_data_i), .ch1_data_i(ch1_data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_data_o(out_data_o), .out_chan_o(out_chan_o), .out_last_o(out_last_o),
      .ovf_o(ovf_o), .busy_o(busy_o)
   );

   function automatic logic [DW-1:0] word(input int c, input int i);
      return {(c == 1) ? 16'hB1B1 : 16'hA0A0, 16'(i)};
   endfunction

   // Preloaded channel FIFOs: word i of channel c is word(c,i); registered read data.
   int unsigned   f_h [2] = '{0, 0};
   int unsigned   f_n [2] = '{0, 0};
   logic [DW-1:0] f_data [2] = '{32'd0, 32'd0};
   logic [1:0]    load_req = 2'b00;
   int unsigned   load_n [2] = '{0, 0};
   logic [1:0]    rd_s;
   assign rd_s = {ch1_rd_en_o, ch0_rd_en_o};

   always @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (load_req[c]) begin
            f_h[c] <= 0;
            f_n[c] <= load_n[c];
         end else if (rd_s[c]) begin
            f_h[c] <= f_h[c] + 1;
         end
         if (rd_s[c]) f_data[c] <= word(c, int'(f_h[c]));
      end
   end
   assign ch0_empty_i = (f_h[0] >= f_n[0]);
   assign ch1_empty_i = (f_h[1] >= f_n[1]);
   assign ch0_data_i  = f_data[0];
   assign ch1_data_i  = f_data[1];

   typedef struct packed {logic chan; logic last; logic [DW-1:0] data;} item_t;
   item_t exp_q[$];
   item_t got_q[$];
   int    got_cyc[$];

   typedef struct {
      logic [1:0] en; int n0; int n1; logic af0; logic af1;
      logic rd0; logic rd1; logic busy;
   } vec_t;
   vec_t tbl [10];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic mon_on = 1'b0;
   logic s_valid = 1'b0, s_chan = 1'b0, s_last = 1'b0, held = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic [1:0] ovf_exp = 2'b00;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: handshake/ovf model at the edge, checks at the falling edge.
   task automatic tick();
      @(posedge clk);
      if (mon_on && s_valid && out_ready_i && !rst_i) begin
         got_q.push_back({s_chan, s_last, s_data});
         got_cyc.push_back(cyc);
      end
      held = s_valid && !out_ready_i && !rst_i;
      if (rst_i) ovf_exp = 2'b00;
      else ovf_exp = {ch1_full_i | (ovf_exp[1] & ~clr_ovf_i), ch0_full_i | (ovf_exp[0] & ~clr_ovf_i)};
      cyc++;
      @(negedge clk);
      check("ovf_model", {62'd0, ovf_o}, {62'd0, ovf_exp});
      if (held) begin
         check("hold_word", {30'd0, out_valid_o, out_chan_o, out_last_o, out_data_o},
               {30'd0, 1'b1, s_chan, s_last, s_data});
      end
      s_valid = out_valid_o;
      s_chan  = out_chan_o;
      s_last  = out_last_o;
      s_data  = out_data_o;
   endtask

   task automatic do_reset(input int n0, input int n1);
      rst_i = 1'b1;
      load_req = 2'b11;
      load_n[0] = n0;
      load_n[1] = n1;
      tick();
      rst_i = 1'b0;
      load_req = 2'b00;
      got_q.delete();
      got_cyc.delete();
   endtask

   task automatic push_burst(input int c, input int start, input int k);
      for (int j = 0; j < k; j++) begin
         item_t it;
         it.data = word(c, start + j);
         it.chan = c[0];
         it.last = (j == k - 1);
         exp_q.push_back(it);
      end
   endtask

   // Reference stream for static FIFO contents: alternate channels, skip empty ones.
   task automatic build_exp(input int n0, input int n1);
      int rem [2];
      int taken [2];
      int nxt, c, k;
      rem[0] = n0; rem[1] = n1;
      taken[0] = 0; taken[1] = 0;
      nxt = 0;
      exp_q.delete();
      while (rem[0] + rem[1] > 0) begin
         c = (rem[nxt] > 0) ? nxt : 1 - nxt;
         k = (rem[c] < BL) ? rem[c] : BL;
         push_burst(c, taken[c], k);
         taken[c] += k;
         rem[c] -= k;
         nxt = 1 - c;
      end
   endtask

   task automatic compare(input string name);
      check($sformatf("%s_len", name), 64'(got_q.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         check($sformatf("%s_w%0d", name, k), {30'd0, got_q[k]}, {30'd0, exp_q[k]});
      end
   endtask

   task automatic run_stream(input string name, input int budget, input bit rnd);
      int i;
      i = 0;
      mon_on = 1'b1;
      while (got_q.size() < exp_q.size() && i < budget) begin
         if (rnd) begin
            out_ready_i = ($urandom_range(0, 3) != 0);
            ch0_full_i  = ($urandom_range(0, 15) == 0);
            ch1_full_i  = ($urandom_range(0, 15) == 0);
            clr_ovf_i   = ($urandom_range(0, 7) == 0);
         end
         tick();
         i++;
      end
      out_ready_i = 1'b1;
      ch0_full_i = 1'b0;
      ch1_full_i = 1'b0;
      clr_ovf_i = 1'b0;
      repeat (6) tick();
      mon_on = 1'b0;
      compare(name);
   endtask

   initial begin
      rst_i = 1'b1; en_i = 2'b11; clr_ovf_i = 1'b0;
      ch0_a_full_i = 1'b0; ch1_a_full_i = 1'b0;
      ch0_full_i = 1'b0; ch1_full_i = 1'b0;
      out_ready_i = 1'b1;

      // Grant decision from reset (last grant = ch1): {en, n0, n1, af0, af1, rd0, rd1, busy}
      tbl[0] = '{2'b11, 2, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[1] = '{2'b11, 2, 2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[2] = '{2'b11, 2, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{2'b11, 2, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{2'b01, 2, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{2'b10, 2, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[6] = '{2'b11, 0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[7] = '{2'b00, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{2'b11, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9] = '{2'b10, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int v = 0; v < 10; v++) begin
         en_i = tbl[v].en;
         ch0_a_full_i = tbl[v].af0;
         ch1_a_full_i = tbl[v].af1;
         do_reset(tbl[v].n0, tbl[v].n1);
         check($sformatf("rst_state_v%0d", v),
               {25'd0, out_valid_o, out_data_o, out_chan_o, out_last_o, busy_o, ch0_rd_en_o, ch1_rd_en_o}, 64'd0);
         tick();
         check($sformatf("grant_v%0d", v), {61'd0, ch0_rd_en_o, ch1_rd_en_o, busy_o},
               {61'd0, tbl[v].rd0, tbl[v].rd1, tbl[v].busy});
      end
      en_i = 2'b11; ch0_a_full_i = 1'b0; ch1_a_full_i = 1'b0;

      // Single channel, 10 words: bursts 4/4/2 with one idle cycle between bursts.
      do_reset(10, 0);
      build_exp(10, 0);
      run_stream("single", 200, 1'b0);
      for (int k = 1; k < got_q.size(); k++)
         check($sformatf("gap_%0d", k), 64'(got_cyc[k] - got_cyc[k-1]), (k % 4 == 0) ? 64'd2 : 64'd1);
      check("ch1_never_read", 64'(f_h[1]), 64'd0);

      // Both channels, 8 words each: alternating 4-word bursts.
      do_reset(8, 8);
      build_exp(8, 8);
      run_stream("alternate", 200, 1'b0);

      // Almost-full ch1 is granted again after its own burst.
      do_reset(0, 8);
      tick();
      load_req = 2'b01; load_n[0] = 8; ch1_a_full_i = 1'b1;
      tick();
      load_req = 2'b00;
      exp_q.delete();
      push_burst(1, 0, 4); push_burst(1, 4, 4); push_burst(0, 0, 4); push_burst(0, 4, 4);
      run_stream("afull", 200, 1'b0);
      ch1_a_full_i = 1'b0;

      // Back-pressure: two strobes then stall; disable ends the burst on the buffered tail.
      out_ready_i = 1'b0;
      do_reset(8, 0);
      repeat (6) tick();
      check("stall_reads", 64'(f_h[0]), 64'd2);
      check("stall_head", {31'd0, out_valid_o, out_data_o}, {31'd0, 1'b1, word(0, 0)});
      en_i = 2'b10;
      tick();
      en_i = 2'b11; out_ready_i = 1'b1;
      exp_q.delete();
      push_burst(0, 0, 2); push_burst(0, 2, 4); push_burst(0, 6, 2);
      run_stream("stall", 200, 1'b0);

      // Channel empties after 2 words: second word is last, arbiter idles.
      do_reset(2, 0);
      build_exp(2, 0);
      run_stream("short", 100, 1'b0);
      check("idle_after_short", {63'd0, busy_o}, 64'd0);

      // Reset mid-burst with a word in flight.
      do_reset(8, 8);
      tick();
      tick();
      rst_i = 1'b1;
      #1;
      check("rd_gated_in_reset", {62'd0, ch0_rd_en_o, ch1_rd_en_o}, 64'd0);
      tick();
      check("midburst_reset_outs",
            {23'd0, out_valid_o, out_data_o, out_chan_o, out_last_o, busy_o, ovf_o, ch0_rd_en_o, ch1_rd_en_o}, 64'd0);
      rst_i = 1'b0;
      tick();
      tick();
      check("post_reset_grant", {62'd0, ch0_rd_en_o, ch1_rd_en_o}, 64'd2);

      // Sticky overflow: set, clear, and set winning over clear.
      ch1_full_i = 1'b1; tick(); ch1_full_i = 1'b0;
      check("ovf_set", {62'd0, ovf_o}, 64'd2);
      clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0;
      check("ovf_clr", {62'd0, ovf_o}, 64'd0);
      ch0_full_i = 1'b1; clr_ovf_i = 1'b1; tick(); ch0_full_i = 1'b0; clr_ovf_i = 1'b0;
      check("ovf_set_wins", {62'd0, ovf_o}, 64'd1);
      clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0;

      // Randomized contents, ready and overflow activity.
      for (int it = 0; it < 6; it++) begin
         int n0, n1;
         n0 = $urandom_range(0, 13);
         n1 = $urandom_range(0, 13);
         do_reset(n0, n1);
         build_exp(n0, n1);
         run_stream($sformatf("rand%0d", it), 600, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Two-channel read-side scheduler for the sample FIFOs. It drains two channel FIFOs (for example the two RF front-end streams) into one tagged output stream toward the host interface.
- Grants bursts of up to BURST_LEN words per channel. Grant order is round-robin, overridden by almost-full priority.
- Provides sticky overflow status per channel.
- Sits in the read-clock domain of both FIFOs; all signals share clk_i.

Parameters:
- DATA_WIDTH, 32, FIFO word width.
- BURST_LEN, 4, maximum words read per grant (1..255).
- CNT_WIDTH, 8, burst counter width; must satisfy 2**CNT_WIDTH > BURST_LEN.

Ports:
- clk_i  in  1  single clock (FIFO read clock).
- rst_i  in  1  reset, synchronous, active-high.
- en_i  in  2  per-channel enable; bit n enables channel n.
- clr_ovf_i  in  1  clears overflow sticky bits.
- ch0_empty_i / ch1_empty_i  in  1  FIFO empty flag.
- ch0_a_full_i / ch1_a_full_i  in  1  FIFO almost-full flag.
- ch0_full_i / ch1_full_i  in  1  FIFO full flag.
- ch0_rd_en_o / ch1_rd_en_o  out  1  FIFO read strobe.
- ch0_data_i / ch1_data_i  in  DATA_WIDTH  FIFO read data, valid the cycle after the strobe.
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  consumer accepts the word when out_valid_o && out_ready_i.
- out_data_o  out  DATA_WIDTH  output word.
- out_chan_o  out  1  source channel of out_data_o.
- out_last_o  out  1  final word of a burst.
- ovf_o  out  2  sticky per-channel overflow flags.
- busy_o  out  1  high in state BURST.

Behaviour:
- Reset values: state IDLE, grant=0, last_grant=1, burst count=0, in-flight=0, buffer empty. out_valid_o=0, out_data_o=0, out_chan_o=0, out_last_o=0, ovf_o=0, busy_o=0, both rd_en_o=0.
- Reset mid-burst: in-flight and buffered words are discarded; rd_en_o is held low during every reset cycle.
- Channel n is eligible when en_i[n] && !chn_empty_i.
- State IDLE:
  - If no channel is eligible, stay in IDLE.
  - If exactly one channel is eligible, grant it.
  - If both are eligible and exactly one has a_full_i high, grant that one.
  - Otherwise grant !last_grant.
  - Move to BURST with count=0 and last_grant set to the granted channel. The IDLE cycle issues no read.
- State BURST, read strobe:
  - rd_en_o[grant] = en_i[grant] && !chgrant_empty_i && space && count < BURST_LEN.
  - rd_en_o is combinational; the FIFO's registered empty flag makes back-to-back strobes safe.
  - The non-granted rd_en_o is always 0.
  - Each strobe increments count and sets in-flight for one cycle, with channel tag and last tag (count+1 == BURST_LEN, or an exit condition is met that same cycle).
- Exit BURST to IDLE when any of:
  - count reaches BURST_LEN;
  - granted channel is empty with no strobe this cycle;
  - en_i[grant] is low.
- Early exit on empty or disable: the last issued word is retroactively flagged last. Implement this with a 1-cycle-late last marking on the buffered entry. If no word was issued in the grant, no last flag is produced.
- Capture: the cycle after a strobe, chX_data_i is written into a 2-entry output FIFO (skid buffer) with its chan and last tags.
- Space rule: space = (occupancy + in_flight - pop) < 2, where pop = out_valid_o && out_ready_i. Overflow of the buffer is impossible by construction.
- Output handshake:
  - out_valid_o = occupancy > 0.
  - Head data and tags are held stable while out_valid_o && !out_ready_i.
  - Zero bubble on a continuous ready: throughput is 1 word per cycle within a burst, plus 1 IDLE cycle between bursts.
- ovf_o[n] is set on any cycle with chn_full_i high. clr_ovf_i clears it; if set and clear occur in the same cycle, set wins.
- busy_o = (state == BURST).

Test Plan:
- ch0 holds 10 words, ch1 empty, out_ready_i=1, BURST_LEN=4 -> output 0,1,2,3 (last on 3), then one IDLE cycle, then 4..7 (last on 7), then 8,9 (last on 9); out_chan_o=0 throughout; no ch1_rd_en_o.
- Both channels hold 8 words, no a_full -> bursts alternate: ch0 words 0-3, ch1 words 0-3, ch0 words 4-7, ch1 words 4-7; out_last_o is asserted on every 4th word.
- Both channels eligible with ch1_a_full_i=1 and last_grant=1 -> ch1 is granted again ahead of round-robin.
- out_ready_i=0 during a burst -> at most 2 strobes are issued, after which rd_en_o stays low. out_data_o is stable. Raising ready drains the words in order with none lost or duplicated.
- ch0 empties after 2 words of a 4-word burst -> word 2 carries out_last_o=1 and the arbiter returns to IDLE.
- rst_i is pulsed mid-burst with 1 word in flight -> next cycle all outputs are at reset values, and the first post-reset grant goes to ch0. Separately: ch1_full_i pulse sets ovf_o=2'b10, and clr_ovf_i clears it to 0.
